// File: rtl/sub_borrow_stream.sv
// sub_borrow_stream: multi-word subtractor, D = A - B - b_in streamed LSW-first one word per cycle
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_valid_i / in_ready_o      input word handshake
//   in_a_i, in_b_i               minuend / subtrahend word
//   in_last_i                    input word is the operand MSW
//   b_in_i                       initial borrow, sampled with the first word of an operand
//   out_valid_o / out_ready_i    result word handshake
//   out_d_o                      difference word
//   out_last_o                   result word is the MSW (natural or forced)
//   out_borrow_o                 final borrow, only on the last word
//   out_ovf_o                    signed overflow on the last word (US=0 only)
//   out_err_o                    operand ran past MAXW words; set on the forced-last word
module sub_borrow_stream #(
    parameter int DW   = 18,
    parameter int US   = 1,
    parameter int MAXW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_a_i,
    input  logic [DW-1:0] in_b_i,
    input  logic          in_last_i,
    input  logic          b_in_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_d_o,
    output logic          out_last_o,
    output logic          out_borrow_o,
    output logic          out_ovf_o,
    output logic          out_err_o
);
    localparam int CW = (MAXW > 1) ? $clog2(MAXW) : 1;
    typedef enum logic {FIRST, MID} state_t;
    state_t        state_q;
    logic          bor_q;
    logic [CW-1:0] cnt_q;
    logic          acc, bor_used, bo, last, ovf;
    logic [DW-1:0] d;
    assign in_ready_o = !out_valid_o | out_ready_i;
    always_comb begin
        acc      = in_valid_i & in_ready_o;
        bor_used = (state_q == FIRST) ? b_in_i : bor_q;
        {bo, d}  = {1'b0, in_a_i} - {1'b0, in_b_i} - (DW+1)'(bor_used);
        // count is 0 in FIRST, so this also forces last on every word when MAXW==1
        last     = in_last_i | (cnt_q == CW'(MAXW - 1));
        ovf      = (US == 0) & (in_a_i[DW-1] != in_b_i[DW-1]) & (d[DW-1] != in_a_i[DW-1]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FIRST;
            bor_q        <= 1'b0;
            cnt_q        <= '0;
            out_valid_o  <= 1'b0;
            out_d_o      <= '0;
            out_last_o   <= 1'b0;
            out_borrow_o <= 1'b0;
            out_ovf_o    <= 1'b0;
            out_err_o    <= 1'b0;
        end else if (acc) begin
            state_q      <= last ? FIRST : MID;
            bor_q        <= last ? 1'b0 : bo;
            cnt_q        <= last ? '0 : cnt_q + CW'(1);
            out_valid_o  <= 1'b1;
            out_d_o      <= d;
            out_last_o   <= last;
            out_borrow_o <= last & bo;
            out_ovf_o    <= last & ovf;
            out_err_o    <= last & !in_last_i;
        end else if (out_ready_i) begin
            out_valid_o  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sub_borrow_stream.sv
// tb_sub_borrow_stream: randomized and directed check of sub_borrow_stream against a wide-integer model
module tb_sub_borrow_stream;
    localparam int DW = 18, MAXW = 8;
    logic clk = 1'b0;
    logic rst, in_valid, in_last, b_in, out_ready;
    logic [DW-1:0] in_a, in_b;
    logic rdy1, ov1, ol1, ob1, oo1, oe1;
    logic rdy0, ov0, ol0, ob0, oo0, oe0;
    logic [DW-1:0] od1, od0;
    always #5 clk = ~clk;

    sub_borrow_stream #(.DW(DW), .US(1), .MAXW(MAXW)) u1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1), .in_a_i(in_a), .in_b_i(in_b),
        .in_last_i(in_last), .b_in_i(b_in), .out_valid_o(ov1), .out_ready_i(out_ready), .out_d_o(od1),
        .out_last_o(ol1), .out_borrow_o(ob1), .out_ovf_o(oo1), .out_err_o(oe1));
    sub_borrow_stream #(.DW(DW), .US(0), .MAXW(MAXW)) u0 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0), .in_a_i(in_a), .in_b_i(in_b),
        .in_last_i(in_last), .b_in_i(b_in), .out_valid_o(ov0), .out_ready_i(out_ready), .out_d_o(od0),
        .out_last_o(ol0), .out_borrow_o(ob0), .out_ovf_o(oo0), .out_err_o(oe0));

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [DW-1:0] d; logic last, bor, ovf, err; } exp_t;
    exp_t q[$];
    logic [159:0] ma, mb;
    logic mbin;
    int mk = 0;

    // Model: keep the whole partial operand as a wide integer and take the word of the full difference
    task automatic model_push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic l, input logic bi);
        exp_t e;
        logic [159:0] mask, hi, as, bs, r, dd;
        int n;
        if (mk == 0) begin ma = '0; mb = '0; mbin = bi; end
        ma[mk*DW +: DW] = a;
        mb[mk*DW +: DW] = b;
        n = (mk + 1) * DW;
        mask = (160'd1 << n) - 160'd1;
        hi = mask >> 1;
        dd = ma - mb - {159'd0, mbin};
        e.d = dd[mk*DW +: DW];
        e.last = l | (mk == MAXW - 1);
        e.err = (mk == MAXW - 1) & !l;
        e.bor = e.last & (ma < mb + {159'd0, mbin});
        as = ma[n-1] ? (ma | ~mask) : ma;
        bs = mb[n-1] ? (mb | ~mask) : mb;
        r = as - bs - {159'd0, mbin};
        e.ovf = e.last & (($signed(r) > $signed(hi)) || ($signed(r) < $signed(~hi)));
        mk = e.last ? 0 : mk + 1;
        q.push_back(e);
    endtask

    task automatic tick(output bit acc);
        logic er;
        exp_t e;
        #1;
        er = (q.size() == 0) | out_ready;
        chk("in_ready_us1", rdy1, er);
        chk("in_ready_us0", rdy0, er);
        chk("valid_us1", ov1, q.size() != 0);
        chk("valid_us0", ov0, q.size() != 0);
        if (q.size() != 0) begin
            e = q[0];
            chk("d_us1", od1, e.d);
            chk("d_us0", od0, e.d);
            chk("last_us1", ol1, e.last);
            chk("last_us0", ol0, e.last);
            chk("borrow_us1", ob1, e.bor);
            chk("borrow_us0", ob0, e.bor);
            chk("ovf_us1", oo1, 1'b0);
            chk("ovf_us0", oo0, e.ovf);
            chk("err_us1", oe1, e.err);
            chk("err_us0", oe0, e.err);
            if (out_ready) void'(q.pop_front());
        end
        acc = in_valid & er;
        if (acc) model_push(in_a, in_b, in_last, b_in);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic l, input logic bi);
        bit acc;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = l; b_in = bi; out_ready = 1'b1;
        tick(acc);
        chk("send_accepted", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {ov1, ov0}, 2'b00);
        chk({tag, "_d"}, {od1, od0}, '0);
        chk({tag, "_flags"}, {ol1, ob1, oo1, oe1, ol0, ob0, oo0, oe0}, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mk = 0;
    endtask

    initial begin
        bit acc;
        int rem, stall;
        logic [DW-1:0] wa [4];
        logic [DW-1:0] wb [4];
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; b_in = 1'b0; out_ready = 1'b1;
        #2;
        do_reset();
        check_zero("reset");

        send(18'd5, 18'd3, 1'b1, 1'b0);
        chk("t1_d", od1, 18'd2);
        chk("t1_borrow", ob1, 1'b0);
        chk("t1_last", ol1, 1'b1);

        send(18'd0, 18'd1, 1'b0, 1'b0);
        chk("t2_lsw", od1, 18'h3FFFF);
        chk("t2_lsw_last", ol1, 1'b0);
        send(18'd1, 18'd0, 1'b1, 1'b0);
        chk("t2_msw", od1, 18'h00000);
        chk("t2_msw_borrow", ob1, 1'b0);
        send(18'd0, 18'd1, 1'b1, 1'b0);
        chk("t2_neg", od1, 18'h3FFFF);
        chk("t2_neg_borrow", ob1, 1'b1);

        send(18'h1FFFF, 18'h3FFFF, 1'b1, 1'b0);
        chk("t3_d", od0, 18'h20000);
        chk("t3_ovf", oo0, 1'b1);
        chk("t3_ovf_us1", oo1, 1'b0);

        for (int i = 0; i < 4; i++) begin wa[i] = DW'($urandom); wb[i] = DW'($urandom); end
        wa[0] = '0; wb[0] = 18'd1;
        stall = 0;
        for (int c = 0, i = 0; i < 4 && c < 40; c++) begin
            in_valid = 1'b1; in_a = wa[i]; in_b = wb[i]; in_last = (i == 3); b_in = 1'b0;
            out_ready = !(c >= 2 && c < 5);
            tick(acc);
            if (!out_ready && !acc) stall++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("t4_stalled", stall, 3);

        for (int i = 0; i < 9; i++) begin
            send(DW'($urandom), DW'($urandom), 1'b0, 1'b1);
            if (i == 7) begin chk("t5_forced_last", ol1, 1'b1); chk("t5_err", oe1, 1'b1); end
            if (i == 8) begin chk("t5_restart_last", ol1, 1'b0); chk("t5_restart_err", oe1, 1'b0); end
        end
        send(DW'($urandom), DW'($urandom), 1'b1, 1'b0);

        send(18'd9, 18'd20, 1'b0, 1'b0);
        send(18'd3, 18'd1, 1'b0, 1'b0);
        do_reset();
        check_zero("t6_reset");
        send(18'd7, 18'd2, 1'b1, 1'b1);
        chk("t6_first_d", od1, 18'd4);
        chk("t6_first_last", ol1, 1'b1);

        rem = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                if (rem == 0) rem = $urandom_range(1, 10);
                in_a = DW'($urandom); in_b = DW'($urandom);
                if ($urandom_range(0, 7) == 0) begin in_a = '0; in_b = '1; end
                in_last = (rem == 1);
                rem--;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            b_in = 1'($urandom);
            tick(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(acc);
        tick(acc);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
